conv_cfg_loader: RTL and testbench
==================================

Name: conv_cfg_loader

Overview:
Initiator for the conv1d memory configuration port (rd_en/wr_en/bank/addr/wr_data/rd_data). It accepts a streamed parameter image on a valid/ready/last interface and writes it word by word into the weight banks and the bias bank. It then reads every location back, checks the read-back against a checksum taken while writing, and reports done/error. It sits between the off-chip parameter source and each conv1d instance.

Parameters:
COLUMN_LEN, 2, elements per column vector; VECTOR_BW = 8*COLUMN_LEN
NUM_FILTERS, 8, entries per bank; ADDR_BW = $clog2(NUM_FILTERS)
FILTER_LEN, 3, weight banks (fixed at 3); bank FILTER_LEN is bias; BANK_BW = $clog2(FILTER_LEN+1)
BIAS_BW, 16, significant low bits of a bias word; TOTAL = (FILTER_LEN+1)*NUM_FILTERS words

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
start_i  in  1  one-cycle pulse; begins a load; ignored unless in IDLE or DONE
data_i  in  VECTOR_BW  parameter word
valid_i  in  1  data_i valid
last_i  in  1  marks the final word of the image
ready_o  out  1  loader accepts a word
rd_en_o  out  1  config read strobe
wr_en_o  out  1  config write strobe
rd_wr_bank_o  out  BANK_BW  target bank
rd_wr_addr_o  out  ADDR_BW  target filter address
wr_data_o  out  VECTOR_BW  write data
rd_data_i  in  VECTOR_BW  read data; valid the cycle after rd_en_o
busy_o  out  1  high in LOAD, VERIFY, DRAIN
done_o  out  1  level; high in DONE
err_o  out  2  0 ok, 1 short image, 2 long image, 3 checksum mismatch

Behaviour:
- Reset: state IDLE. Every output is 0, including all config outputs, the counters and the checksums. A reset mid-load aborts immediately with no further strobes.
- States: IDLE -> LOAD on start_i. LOAD -> VERIFY after the TOTAL-th accepted word when last_i is set on it. LOAD -> DONE early on a length error. VERIFY -> DRAIN after issuing the TOTAL-th read. DRAIN -> DONE after one cycle. DONE -> LOAD on start_i. DONE holds otherwise.
- On start_i: clear the counters, both checksums and err_o, and deassert done_o in the same edge.
- LOAD:
  - ready_o=1 combinationally in LOAD, except in the cycle the final write is being issued.
  - A word is accepted when valid_i&&ready_o.
  - Each accepted word produces exactly one wr_en_o pulse on the next cycle, with registered bank/addr/data. Write latency is 1 cycle and throughput is 1 word/cycle.
- Order is bank-major: bank 0 addr 0..NUM_FILTERS-1, then bank 1, bank 2, then bias bank FILTER_LEN. The addr counter wraps to 0 and increments the bank.
- Write checksum: wsum += word mod 2^VECTOR_BW. For bank FILTER_LEN the word is masked to its low min(BIAS_BW,VECTOR_BW) bits before summing.
- Length errors:
  - last_i on an accepted word with index < TOTAL-1: write that word, then go to DONE with err_o=1.
  - Accepted word index TOTAL-1 without last_i: write that word, then go to DONE with err_o=2. Later input stays unaccepted (ready_o=0).
- VERIFY:
  - Starts the cycle after the final write, with wr_en_o already low.
  - Issues rd_en_o every cycle for the same bank/addr order: TOTAL consecutive pulses.
  - rd_data_i is sampled one cycle after each rd_en_o and accumulated into rsum with the same masking rule.
  - rd_en_o and wr_en_o are never high in the same cycle.
- DRAIN: samples the last read word. On entry to DONE, err_o=3 if rsum != wsum, otherwise 0.
- Config outputs are 0 whenever their strobe is low.
- valid_i/last_i are ignored outside LOAD.
- ready_o=0 in IDLE, VERIFY, DRAIN and DONE.
- A start_i pulse while busy_o has no effect.

Test Plan:
- Reset then start_i, stream words 0..31 back-to-back with last_i on word 31 (defaults) -> 32 wr_en pulses at bank0 addr0 … bank3 addr7 with data=index. Then 32 rd_en pulses in the same order. Memory model echo gives done_o=1, err_o=0 and wsum=0x01F0. Total from start_i to done_o is 66 cycles.
- Same stream with valid_i toggled 1,0 and random stalls -> identical write sequence, no duplicate or missing wr_en, result err_o=0.
- last_i asserted on word 10 -> 11 writes (bank1 addr2 last), no rd_en pulses, done_o=1, err_o=1.
- 32 words without last_i, then extra words offered -> 32 writes, ready_o=0 afterwards, err_o=2, no reads.
- Memory model corrupts the read of bank2 addr5 by +1 -> err_o=3, done_o=1.
- Assert rst_n_i low at write 15, then release and start_i again -> all outputs 0 during reset, no strobes after it, and a fresh full load passes with err_o=0.

Source files
------------

// File: rtl/conv_cfg_loader.sv
// Streams a parameter image into the conv1d weight/bias banks, reads every
// location back and compares a read-back checksum against the write checksum.
module conv_cfg_loader #(
  parameter int  COLUMN_LEN  = 2,
  parameter int  NUM_FILTERS = 8,
  parameter int  FILTER_LEN  = 3,
  parameter int  BIAS_BW     = 16,
  localparam int VECTOR_BW   = 8 * COLUMN_LEN,
  localparam int ADDR_BW     = $clog2(NUM_FILTERS),
  localparam int BANK_BW     = $clog2(FILTER_LEN + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 start_i,
  input  logic [VECTOR_BW-1:0] data_i,
  input  logic                 valid_i,
  input  logic                 last_i,
  output logic                 ready_o,
  output logic                 rd_en_o,
  output logic                 wr_en_o,
  output logic [BANK_BW-1:0]   rd_wr_bank_o,
  output logic [ADDR_BW-1:0]   rd_wr_addr_o,
  output logic [VECTOR_BW-1:0] wr_data_o,
  input  logic [VECTOR_BW-1:0] rd_data_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [1:0]           err_o
);

  localparam logic [BANK_BW-1:0]   BIAS_BANK = BANK_BW'(FILTER_LEN);
  localparam logic [ADDR_BW-1:0]   LAST_ADDR = ADDR_BW'(NUM_FILTERS - 1);
  localparam int                   MASK_BW   = (BIAS_BW < VECTOR_BW) ? BIAS_BW : VECTOR_BW;
  localparam logic [VECTOR_BW-1:0] BIAS_MASK = {VECTOR_BW{1'b1}} >> (VECTOR_BW - MASK_BW);

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_SHORT = 2'd1;
  localparam logic [1:0] ERR_LONG  = 2'd2;
  localparam logic [1:0] ERR_SUM   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_VERIFY = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t               state_q;
  logic [BANK_BW-1:0]   bank_q;
  logic [ADDR_BW-1:0]   addr_q;
  logic [VECTOR_BW-1:0] wsum_q;
  logic [VECTOR_BW-1:0] rsum_q;
  logic                 final_q;
  logic [1:0]           err_pend_q;
  logic                 rd_pend_q;
  logic [BANK_BW-1:0]   rd_bank_pend_q;
  logic                 wr_en_q;
  logic                 rd_en_q;
  logic [BANK_BW-1:0]   rd_wr_bank_q;
  logic [ADDR_BW-1:0]   rd_wr_addr_q;
  logic [VECTOR_BW-1:0] wr_data_q;
  logic                 done_q;
  logic [1:0]           err_q;

  logic                 at_end_d;
  logic [BANK_BW-1:0]   bank_nx_d;
  logic [ADDR_BW-1:0]   addr_nx_d;
  logic [VECTOR_BW-1:0] wsum_d;
  logic [VECTOR_BW-1:0] rsum_d;

  // Bias words only contribute their significant low bits to either checksum.
  function automatic logic [VECTOR_BW-1:0] sum_term(input logic [VECTOR_BW-1:0] word,
                                                    input logic [BANK_BW-1:0]   bank);
    if (bank == BIAS_BANK) begin
      sum_term = word & BIAS_MASK;
    end else begin
      sum_term = word;
    end
  endfunction

  // Bank-major address walk and checksum next values.
  always_comb begin
    at_end_d  = (bank_q == BIAS_BANK) && (addr_q == LAST_ADDR);
    addr_nx_d = addr_q + ADDR_BW'(1);
    bank_nx_d = bank_q;
    if (addr_q == LAST_ADDR) begin
      addr_nx_d = ADDR_BW'(0);
      bank_nx_d = bank_q + BANK_BW'(1);
    end else begin
      bank_nx_d = bank_q;
    end
    wsum_d = wsum_q + sum_term(data_i, bank_q);
    if (rd_pend_q) begin
      rsum_d = rsum_q + sum_term(rd_data_i, rd_bank_pend_q);
    end else begin
      rsum_d = rsum_q;
    end
  end

  // Control FSM with registered config strobes, bus and status.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q        <= S_IDLE;
      bank_q         <= BANK_BW'(0);
      addr_q         <= ADDR_BW'(0);
      wsum_q         <= VECTOR_BW'(0);
      rsum_q         <= VECTOR_BW'(0);
      final_q        <= 1'b0;
      err_pend_q     <= ERR_OK;
      rd_pend_q      <= 1'b0;
      rd_bank_pend_q <= BANK_BW'(0);
      wr_en_q        <= 1'b0;
      rd_en_q        <= 1'b0;
      rd_wr_bank_q   <= BANK_BW'(0);
      rd_wr_addr_q   <= ADDR_BW'(0);
      wr_data_q      <= VECTOR_BW'(0);
      done_q         <= 1'b0;
      err_q          <= ERR_OK;
    end else begin
      wr_en_q        <= 1'b0;
      rd_en_q        <= 1'b0;
      rd_wr_bank_q   <= BANK_BW'(0);
      rd_wr_addr_q   <= ADDR_BW'(0);
      wr_data_q      <= VECTOR_BW'(0);
      rd_pend_q      <= rd_en_q;
      rd_bank_pend_q <= rd_wr_bank_q;
      rsum_q         <= rsum_d;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_q    <= S_LOAD;
            bank_q     <= BANK_BW'(0);
            addr_q     <= ADDR_BW'(0);
            wsum_q     <= VECTOR_BW'(0);
            rsum_q     <= VECTOR_BW'(0);
            final_q    <= 1'b0;
            err_pend_q <= ERR_OK;
            done_q     <= 1'b0;
            err_q      <= ERR_OK;
          end else begin
            state_q <= state_q;
          end
        end
        S_LOAD: begin
          if (final_q) begin
            final_q <= 1'b0;
            bank_q  <= BANK_BW'(0);
            addr_q  <= ADDR_BW'(0);
            if (err_pend_q == ERR_OK) begin
              // First read goes out together with the move into VERIFY.
              state_q <= S_VERIFY;
              rd_en_q <= 1'b1;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              err_q   <= err_pend_q;
            end
          end else if (valid_i) begin
            wr_en_q      <= 1'b1;
            rd_wr_bank_q <= bank_q;
            rd_wr_addr_q <= addr_q;
            wr_data_q    <= data_i;
            wsum_q       <= wsum_d;
            if (at_end_d) begin
              final_q    <= 1'b1;
              err_pend_q <= last_i ? ERR_OK : ERR_LONG;
            end else if (last_i) begin
              final_q    <= 1'b1;
              err_pend_q <= ERR_SHORT;
            end else begin
              bank_q <= bank_nx_d;
              addr_q <= addr_nx_d;
            end
          end else begin
            final_q <= 1'b0;
          end
        end
        S_VERIFY: begin
          if (at_end_d) begin
            state_q <= S_DRAIN;
          end else begin
            rd_en_q      <= 1'b1;
            rd_wr_bank_q <= bank_nx_d;
            rd_wr_addr_q <= addr_nx_d;
            bank_q       <= bank_nx_d;
            addr_q       <= addr_nx_d;
          end
        end
        S_DRAIN: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
          err_q   <= (rsum_d != wsum_q) ? ERR_SUM : ERR_OK;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ready_o      = (state_q == S_LOAD) && !final_q;
  assign busy_o       = (state_q == S_LOAD) || (state_q == S_VERIFY) || (state_q == S_DRAIN);
  assign wr_en_o      = wr_en_q;
  assign rd_en_o      = rd_en_q;
  assign rd_wr_bank_o = rd_wr_bank_q;
  assign rd_wr_addr_o = rd_wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_conv_cfg_loader.sv
// Self-checking bench for conv_cfg_loader: echo memory model, bus monitor and
// a checksum/length reference model computed from the image contents.
module tb_conv_cfg_loader;
  localparam int NF = 8;
  localparam int NB = 4;
  localparam int TOTAL = NF * NB;
  localparam int BIAS_MOD = 65536;

  logic        clk = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        start_i = 1'b0;
  logic [15:0] data_i = 16'd0;
  logic        valid_i = 1'b0;
  logic        last_i = 1'b0;
  logic        ready_o, rd_en_o, wr_en_o, busy_o, done_o;
  logic [1:0]  rd_wr_bank_o;
  logic [2:0]  rd_wr_addr_o;
  logic [15:0] wr_data_o;
  logic [15:0] rd_data_i = 16'd0;
  logic [1:0]  err_o;

  conv_cfg_loader dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .start_i(start_i), .data_i(data_i),
    .valid_i(valid_i), .last_i(last_i), .ready_o(ready_o), .rd_en_o(rd_en_o),
    .wr_en_o(wr_en_o), .rd_wr_bank_o(rd_wr_bank_o), .rd_wr_addr_o(rd_wr_addr_o),
    .wr_data_o(wr_data_o), .rd_data_i(rd_data_i), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  int overlap = 0;
  int junk = 0;
  int wbase, rbase, obase, jbase;
  bit corrupt = 1'b0;
  logic [20:0] wr_log[$];
  logic [4:0]  rd_log[$];
  logic [15:0] mem[NB][NF];
  logic [15:0] rd_pipe = 16'd0;
  logic [15:0] words[TOTAL];

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor plus config memory with one-cycle read latency.
  always @(negedge clk) begin
    if (wr_en_o) begin
      wr_log.push_back({rd_wr_bank_o, rd_wr_addr_o, wr_data_o});
      mem[rd_wr_bank_o][rd_wr_addr_o] <= wr_data_o;
    end
    if (rd_en_o) rd_log.push_back({rd_wr_bank_o, rd_wr_addr_o});
    if (wr_en_o && rd_en_o) overlap <= overlap + 1;
    if (!wr_en_o && !rd_en_o && ({rd_wr_bank_o, rd_wr_addr_o} != 5'd0)) junk <= junk + 1;
    if (!wr_en_o && (wr_data_o != 16'd0)) junk <= junk + 1;
    rd_data_i <= rd_pipe;
    if (rd_en_o)
      rd_pipe <= mem[rd_wr_bank_o][rd_wr_addr_o] +
                 ((corrupt && rd_wr_bank_o == 2'd2 && rd_wr_addr_o == 3'd5) ? 16'd1 : 16'd0);
    else
      rd_pipe <= 16'd0;
  end

  function automatic logic [20:0] exp_wr(input int i);
    logic [1:0] b;
    logic [2:0] a;
    b = 2'(i / NF);
    a = 3'(i % NF);
    return {b, a, words[i]};
  endfunction

  function automatic logic [4:0] exp_rd(input int i);
    logic [1:0] b;
    logic [2:0] a;
    b = 2'(i / NF);
    a = 3'(i % NF);
    return {b, a};
  endfunction

  // Reference: length rules first, then compare image sum with echoed sum.
  function automatic logic [1:0] model_err(input int last_at, input bit corr);
    int wsum, rsum, wt, rt;
    wsum = 0;
    rsum = 0;
    if (last_at < TOTAL - 1) return 2'd1;
    if (last_at > TOTAL - 1) return 2'd2;
    for (int i = 0; i < TOTAL; i++) begin
      wt = int'(words[i]);
      rt = (wt + ((corr && i == 2 * NF + 5) ? 1 : 0)) % 65536;
      if (i / NF == NB - 1) begin
        wt = wt % BIAS_MOD;
        rt = rt % BIAS_MOD;
      end
      wsum = (wsum + wt) % 65536;
      rsum = (rsum + rt) % 65536;
    end
    return (wsum != rsum) ? 2'd3 : 2'd0;
  endfunction

  task automatic do_start();
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    start_cyc = cyc;
    wbase = wr_log.size();
    rbase = rd_log.size();
    obase = overlap;
    jbase = junk;
  endtask

  task automatic drive(input int n, input int last_at, input bit stall, input bit poke);
    int  k;
    int  g;
    bit  acc;
    k = 0;
    g = 0;
    while (k < n && g < 4000) begin
      if (stall) valid_i = (g % 2 == 0) && ($urandom_range(3) != 0);
      else valid_i = 1'b1;
      data_i  = valid_i ? words[k] : 16'($urandom);
      last_i  = valid_i ? (k == last_at) : 1'($urandom);
      start_i = poke && (g == 9);
      acc = valid_i && ready_o;
      @(negedge clk);
      if (acc) k++;
      g++;
    end
    valid_i = 1'b0;
    last_i  = 1'b0;
    data_i  = 16'd0;
    start_i = 1'b0;
    total++;
    if (k != n) begin
      bad++;
      $display("FAIL drive_accept got=%0d want=%0d", k, n);
    end
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 0; i < 300; i++) begin
      if (done_o) begin
        lat = cyc - start_cyc;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (lat < 0) begin
      bad++;
      $display("FAIL done_timeout got=none want=done_o");
    end
  endtask

  task automatic test_reset();
    logic [27:0] outs;
    rst_n_i = 1'b0;
    repeat (3) @(negedge clk);
    outs = {ready_o, rd_en_o, wr_en_o, rd_wr_bank_o, rd_wr_addr_o, wr_data_o, busy_o, done_o, err_o};
    total++;
    if (outs !== 28'd0) begin bad++; $display("FAIL reset_outputs got=%h want=0", outs); end
    rst_n_i = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_load(input bit rnd, input bit stall, input bit corr, input string tag);
    int lat, nw, nr;
    logic [1:0] exp_e;
    for (int i = 0; i < TOTAL; i++) words[i] = rnd ? 16'($urandom) : 16'(i);
    corrupt = corr;
    exp_e = model_err(TOTAL - 1, corr);
    do_start();
    drive(TOTAL, TOTAL - 1, stall, stall);
    wait_done(lat);
    nw = wr_log.size() - wbase;
    nr = rd_log.size() - rbase;
    if (!stall) begin
      total++;
      if (lat != 66) begin bad++; $display("FAIL %s latency got=%0d want=66", tag, lat); end
    end
    total++;
    if (nw != TOTAL) begin bad++; $display("FAIL %s wr_count got=%0d want=%0d", tag, nw, TOTAL); end
    for (int i = 0; i < TOTAL && i < nw; i++) begin
      total++;
      if (wr_log[wbase+i] !== exp_wr(i)) begin
        bad++; $display("FAIL %s wr_seq[%0d] got=%h want=%h", tag, i, wr_log[wbase+i], exp_wr(i));
      end
    end
    total++;
    if (nr != TOTAL) begin bad++; $display("FAIL %s rd_count got=%0d want=%0d", tag, nr, TOTAL); end
    for (int i = 0; i < TOTAL && i < nr; i++) begin
      total++;
      if (rd_log[rbase+i] !== exp_rd(i)) begin
        bad++; $display("FAIL %s rd_seq[%0d] got=%h want=%h", tag, i, rd_log[rbase+i], exp_rd(i));
      end
    end
    total++;
    if ({done_o, busy_o, err_o} !== {1'b1, 1'b0, exp_e}) begin
      bad++; $display("FAIL %s result got=done%0d busy%0d err%0d want=done1 busy0 err%0d",
                      tag, done_o, busy_o, err_o, exp_e);
    end
    total++;
    if ((overlap - obase) != 0 || (junk - jbase) != 0) begin
      bad++; $display("FAIL %s bus_hygiene got=overlap%0d junk%0d want=0", tag, overlap - obase, junk - jbase);
    end
    corrupt = 1'b0;
  endtask

  task automatic test_short_image();
    int lat, nw, nr;
    for (int i = 0; i < TOTAL; i++) words[i] = 16'($urandom);
    do_start();
    drive(11, 10, 1'b0, 1'b0);
    wait_done(lat);
    repeat (3) @(negedge clk);
    nw = wr_log.size() - wbase;
    nr = rd_log.size() - rbase;
    total++;
    if (nw != 11) begin bad++; $display("FAIL short wr_count got=%0d want=11", nw); end
    for (int i = 0; i < 11 && i < nw; i++) begin
      total++;
      if (wr_log[wbase+i] !== exp_wr(i)) begin
        bad++; $display("FAIL short wr_seq[%0d] got=%h want=%h", i, wr_log[wbase+i], exp_wr(i));
      end
    end
    total++;
    if (nr != 0) begin bad++; $display("FAIL short rd_count got=%0d want=0", nr); end
    total++;
    if ({done_o, err_o} !== {1'b1, model_err(10, 1'b0)}) begin
      bad++; $display("FAIL short result got=done%0d err%0d want=done1 err1", done_o, err_o);
    end
  endtask

  task automatic test_long_image();
    int lat, nw, nr;
    for (int i = 0; i < TOTAL; i++) words[i] = 16'($urandom);
    do_start();
    drive(TOTAL, 1000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      valid_i = 1'b1;
      data_i  = 16'($urandom);
      last_i  = 1'b1;
      total++;
      if (ready_o !== 1'b0) begin bad++; $display("FAIL long ready_after[%0d] got=%0d want=0", i, ready_o); end
      @(negedge clk);
    end
    valid_i = 1'b0;
    last_i  = 1'b0;
    wait_done(lat);
    nw = wr_log.size() - wbase;
    nr = rd_log.size() - rbase;
    total++;
    if (nw != TOTAL) begin bad++; $display("FAIL long wr_count got=%0d want=%0d", nw, TOTAL); end
    total++;
    if (nr != 0) begin bad++; $display("FAIL long rd_count got=%0d want=0", nr); end
    total++;
    if ({done_o, err_o} !== {1'b1, model_err(1000, 1'b0)}) begin
      bad++; $display("FAIL long result got=done%0d err%0d want=done1 err2", done_o, err_o);
    end
  endtask

  task automatic test_reset_midload();
    logic [27:0] outs;
    int nw, nr;
    for (int i = 0; i < TOTAL; i++) words[i] = 16'($urandom);
    do_start();
    drive(16, 1000, 1'b0, 1'b0);
    rst_n_i = 1'b0;
    #1;
    wbase = wr_log.size();
    rbase = rd_log.size();
    outs = {ready_o, rd_en_o, wr_en_o, rd_wr_bank_o, rd_wr_addr_o, wr_data_o, busy_o, done_o, err_o};
    total++;
    if (outs !== 28'd0) begin bad++; $display("FAIL midreset_outputs got=%h want=0", outs); end
    repeat (4) @(negedge clk);
    nw = wr_log.size() - wbase;
    nr = rd_log.size() - rbase;
    total++;
    if (nw != 0 || nr != 0) begin bad++; $display("FAIL midreset_strobes got=wr%0d rd%0d want=0", nw, nr); end
    rst_n_i = 1'b1;
    @(negedge clk);
    test_full_load(1'b1, 1'b0, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_full_load(1'b0, 1'b0, 1'b0, "index");
    test_full_load(1'b1, 1'b1, 1'b0, "stall");
    test_short_image();
    test_long_image();
    test_full_load(1'b1, 1'b0, 1'b1, "corrupt");
    test_reset_midload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
